// File: rtl/ps2_kbd_pkg.sv
// Shared types for the PS/2-to-CPC keyboard matrix: decoder states, matrix
// geometry and the scan-code to matrix-position mapping.
package ps2_kbd_pkg;

    localparam int unsigned ROW_W    = 4;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned NUM_ROWS = 10;
    localparam int unsigned NUM_COLS = 8;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK,
        DEC_PAUSE
    } dec_state_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cpc_key_t;

    function automatic cpc_key_t scan_to_cpc(input logic ext, input logic [7:0] code);
        cpc_key_t k;
        k = '0;
        case ({ext, code})
            9'h029: k = '{1'b1, 4'd5, 3'd7};   // Space
            9'h01C: k = '{1'b1, 4'd8, 3'd5};   // A
            9'h05A: k = '{1'b1, 4'd2, 3'd2};   // Enter
            9'h076: k = '{1'b1, 4'd8, 3'd2};   // Esc
            9'h032: k = '{1'b1, 4'd6, 3'd6};   // B
            9'h021: k = '{1'b1, 4'd7, 3'd6};   // C
            9'h023: k = '{1'b1, 4'd7, 3'd5};   // D
            9'h024: k = '{1'b1, 4'd7, 3'd2};   // E
            9'h02B: k = '{1'b1, 4'd6, 3'd5};   // F
            9'h016: k = '{1'b1, 4'd8, 3'd0};   // 1
            9'h01E: k = '{1'b1, 4'd8, 3'd1};   // 2
            9'h012: k = '{1'b1, 4'd2, 3'd5};   // Left shift
            9'h014: k = '{1'b1, 4'd2, 3'd7};   // Ctrl
            9'h066: k = '{1'b1, 4'd9, 3'd7};   // Backspace
            9'h00D: k = '{1'b1, 4'd8, 3'd4};   // Tab
            9'h175: k = '{1'b1, 4'd0, 3'd0};   // Up
            9'h172: k = '{1'b1, 4'd0, 3'd2};   // Down
            9'h16B: k = '{1'b1, 4'd1, 3'd0};   // Left
            9'h174: k = '{1'b1, 4'd0, 3'd1};   // Right
            9'h171: k = '{1'b1, 4'd2, 3'd0};   // Delete
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, shifts in 11-bit
// frames and strobes each good byte; bad frames pulse frame_err.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TC_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        RX_IDLE,
        RX_DATA
    } rx_state_t;

    rx_state_t     state, state_n;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          parity, parity_n;
    logic [TW-1:0] tcount, tcount_n;
    logic [7:0]    byte_n;
    logic          valid_n, err_n;
    logic          fall, data_s;

    // clk_sync[2] holds the previous synchronised level for edge detection
    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tcount     <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            parity     <= parity_n;
            tcount     <= tcount_n;
            byte_data  <= byte_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity;
        tcount_n  = tcount;
        byte_n    = byte_data;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            RX_IDLE: begin
                tcount_n = '0;
                if (fall && !data_s) begin
                    state_n   = RX_DATA;
                    bit_cnt_n = 4'd1;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    tcount_n  = '0;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd8) begin
                        shift_n = {data_s, shift[7:1]};
                    end else if (bit_cnt == 4'd9) begin
                        parity_n = data_s;
                    end else begin
                        state_n   = RX_IDLE;
                        bit_cnt_n = '0;
                        if (data_s && (^{shift, parity})) begin
                            valid_n = 1'b1;
                            byte_n  = shift;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if (tcount == TC_MAX) begin
                    state_n   = RX_IDLE;
                    bit_cnt_n = '0;
                    tcount_n  = '0;
                end else begin
                    tcount_n = tcount + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard to CPC-style 10x8 active-low key matrix, read by the PPI
// through row_sel/row_data.
module ps2_key_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row_sel,
    output logic [7:0] row_data,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    dec_state_t state, state_n;
    logic [2:0] pause_cnt, pause_cnt_n;
    logic       key_upd, key_make, release_all;
    logic       ext;
    cpc_key_t   map;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (frame_err)
    );

    assign ext = (state == DEC_EXT) || (state == DEC_EXT_BRK);
    assign map = scan_to_cpc(ext, rx_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DEC_IDLE;
            pause_cnt <= '0;
            key_event <= 1'b0;
        end else begin
            state     <= state_n;
            pause_cnt <= pause_cnt_n;
            key_event <= key_upd;
        end
    end

    always_comb begin
        state_n     = state;
        pause_cnt_n = pause_cnt;
        key_upd     = 1'b0;
        key_make    = 1'b0;
        release_all = 1'b0;
        if (rx_valid) begin
            case (state)
                DEC_IDLE: begin
                    case (rx_byte)
                        8'hE0: state_n = DEC_EXT;
                        8'hF0: state_n = DEC_BRK;
                        8'hE1: begin
                            state_n     = DEC_PAUSE;
                            pause_cnt_n = '0;
                        end
                        8'hAA, 8'h00, 8'hFF: release_all = 1'b1;
                        8'hFA, 8'hFE, 8'hEE: ;
                        default: begin
                            key_upd  = map.valid;
                            key_make = 1'b1;
                        end
                    endcase
                end
                DEC_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        state_n = DEC_EXT_BRK;
                    end else begin
                        key_upd  = map.valid;
                        key_make = 1'b1;
                        state_n  = DEC_IDLE;
                    end
                end
                DEC_BRK, DEC_EXT_BRK: begin
                    key_upd = map.valid;
                    state_n = DEC_IDLE;
                end
                DEC_PAUSE: begin
                    if (pause_cnt == 3'd6) state_n = DEC_IDLE;
                    else pause_cnt_n = pause_cnt + 3'd1;
                end
                default: state_n = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix <= '1;
        end else if (release_all) begin
            matrix <= '1;
        end else if (key_upd) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                if (map.row == ROW_W'(r)) matrix[r][map.col] <= ~key_make;
            end
        end
    end

    // Rows 10-15 have no keys and always read as released
    always_comb begin
        row_data = '1;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_sel == ROW_W'(r)) row_data = matrix[r];
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: PS/2 frames are bit-banged and the
// expected key_event/frame_err pulses are queued and matched on arrival.
module tb_ps2_key_matrix;

    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] row_sel;
    logic [7:0] row_data;
    logic       key_event;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] row;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ps2_key_matrix #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .row_sel  (row_sel),
        .row_data (row_data),
        .key_event(key_event),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_event === 1'b1 || frame_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {6'd0, frame_err, key_event}, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_frame_err", {7'd0, frame_err}, {7'd0, e.is_err});
                    chk("event_key_event", {7'd0, key_event}, {7'd0, !e.is_err});
                    if (!e.is_err) chk("event_row_data", row_data, e.row);
                end
            end
        end
    endtask

    task automatic push_key(input logic [7:0] row);
        exp_t e;
        e.is_err = 1'b0;
        e.row    = row;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.row    = 8'hFF;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input int unsigned edges, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int unsigned i = 0; i < edges; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(30);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 11, 1'b0);
    endtask

    task automatic drained(input string tag);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d pending events expected 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_all_rows(input string tag);
        for (int unsigned r = 0; r < 16; r++) begin
            row_sel = 4'(r);
            #1;
            chk(tag, row_data, 8'hFF);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        row_sel  = 4'd0;
        tick(4);
        chk("reset_key_event", {7'd0, key_event}, 8'h00);
        chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
        reset_n = 1'b1;
        tick(3);
        check_all_rows("reset_rows");

        // A make / break on row 8
        row_sel = 4'd8;
        push_key(8'hDF);
        send(8'h1C);
        chk("a_make_row8", row_data, 8'hDF);
        send(8'hF0);
        push_key(8'hFF);
        send(8'h1C);
        chk("a_break_row8", row_data, 8'hFF);
        drained("a_events");

        // Extended Up vs plain 0x75
        row_sel = 4'd0;
        send(8'hE0);
        push_key(8'hFE);
        send(8'h75);
        chk("up_make_row0", row_data, 8'hFE);
        send(8'hE0);
        send(8'hF0);
        push_key(8'hFF);
        send(8'h75);
        chk("up_break_row0", row_data, 8'hFF);
        send(8'h75);
        chk("plain75_row0", row_data, 8'hFF);
        drained("up_events");

        // Bad parity on Space
        row_sel = 4'd5;
        push_err();
        send_frame(8'h29, 11, 1'b1);
        chk("bad_parity_row5", row_data, 8'hFF);
        drained("parity_events");

        // Partial frame abandoned by timeout, then Enter
        row_sel = 4'd2;
        send_frame(8'h1C, 5, 1'b0);
        tick(TMO + 1);
        push_key(8'hFB);
        send(8'h5A);
        chk("timeout_enter_row2", row_data, 8'hFB);
        drained("timeout_events");

        // A + Space held, then self-test-passed releases everything
        row_sel = 4'd8;
        push_key(8'hDF);
        send(8'h1C);
        row_sel = 4'd5;
        push_key(8'h7F);
        send(8'h29);
        chk("space_make_row5", row_data, 8'h7F);
        send(8'hAA);
        chk("aa_row5", row_data, 8'hFF);
        row_sel = 4'd8;
        #1;
        chk("aa_row8", row_data, 8'hFF);
        row_sel = 4'd2;
        #1;
        chk("aa_row2", row_data, 8'hFF);
        drained("aa_events");

        // Pause sequence swallows its 7 trailing bytes
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        check_all_rows("pause_rows");
        row_sel = 4'd8;
        push_key(8'hFB);
        send(8'h76);
        chk("esc_row8", row_data, 8'hFB);
        drained("pause_events");

        // Reset in the middle of a frame with keys held
        push_key(8'hDB);
        send(8'h1C);
        chk("a_esc_row8", row_data, 8'hDB);
        send_frame(8'h29, 4, 1'b0);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        check_all_rows("midreset_rows");
        row_sel = 4'd2;
        push_key(8'hFB);
        send(8'h5A);
        chk("post_reset_row2", row_data, 8'hFB);
        drained("reset_events");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
